// File: rtl/rle_pkg.sv
// Shared definitions for the capture-path run-length encoder:
// byte-group width codes, count convention and flag-bit position.
package rle_pkg;

  localparam logic [3:0] DG_W8  = 4'b1110;
  localparam logic [3:0] DG_W16 = 4'b1100;
  localparam logic [3:0] DG_W24 = 4'b1000;

  typedef enum logic [1:0] {
    RLE_REPEATS = 2'd0,
    RLE_LENGTH  = 2'd1
  } rle_mode_t;

  // Flag bit sits at the MSB of the active sample width; any other code means 32 bits.
  function automatic logic [4:0] flag_pos(input logic [3:0] disabled_groups);
    case (disabled_groups)
      DG_W8:   return 5'd7;
      DG_W16:  return 5'd15;
      DG_W24:  return 5'd23;
      default: return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/rle_out_fifo.sv
// Two-entry output queue with same-cycle bypass; accepts up to two words
// per cycle and presents the oldest pending word as a combinational head.
module rle_out_fifo
  import rle_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [1:0]    push_n,
  input  logic [DW-1:0] push_w0,
  input  logic [DW-1:0] push_w1,
  input  logic          pop,
  output logic          head_vld,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic [1:0]    cnt_q;
  logic [1:0]    cnt_d;
  logic [DW-1:0] lst0, lst1, lst2;
  logic [2:0]    len, len_d;
  logic          do_pop;

  // Stored words first, then this cycle's pushes; a third stored word is never needed.
  always_comb begin
    lst0 = push_w0;
    lst1 = push_w1;
    lst2 = '0;
    case (cnt_q)
      2'd0: begin
        lst0 = push_w0;
        lst1 = push_w1;
      end
      2'd1: begin
        lst0 = mem_q[0];
        lst1 = push_w0;
        lst2 = push_w1;
      end
      default: begin
        lst0 = mem_q[0];
        lst1 = mem_q[1];
        lst2 = push_w0;
      end
    endcase
  end

  assign len       = {1'b0, cnt_q} + {1'b0, push_n};
  assign head_vld  = (len != 3'd0);
  assign head_data = head_vld ? lst0 : '0;
  assign do_pop    = pop && head_vld;

  always_comb begin
    mem_d[0] = lst0;
    mem_d[1] = lst1;
    len_d    = len;
    if (do_pop) begin
      mem_d[0] = lst1;
      mem_d[1] = lst2;
      len_d    = len - 3'd1;
    end
    cnt_d = (len_d > 3'd2) ? 2'd2 : len_d[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q[0] <= mem_d[0];
    mem_q[1] <= mem_d[1];
  end

endmodule

// File: rtl/rle_encoder.sv
// Run-length encoder between the sampler/trigger path and sample memory:
// pass-through when not armed, otherwise value words plus flagged run counts.
module rle_encoder
  import rle_pkg::*;
#(
  parameter int DW = 32,
  parameter int KW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          arm,
  input  logic [1:0]    rle_mode,
  input  logic [KW-1:0] disabledGroups,
  input  logic [DW-1:0] sti_data,
  input  logic          sti_valid,
  output logic [DW-1:0] sto_data,
  output logic          sto_valid
);

  logic          active;
  logic          mode1;
  logic [4:0]    fpos;
  logic [DW-1:0] fmask;
  logic [DW-1:0] flag_bit;
  logic [DW-1:0] din_f;

  logic [DW-1:0] last_q, last_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          have_last_q, have_last_d;

  logic [DW-1:0] cnt_inc;
  logic [DW-1:0] cnt_emit;
  logic          eq, sat;

  logic [1:0]    push_n;
  logic [DW-1:0] push_w0, push_w1;
  logic          head_vld;
  logic [DW-1:0] head_data;

  logic [DW-1:0] data_p1;
  logic          vld_p1;

  assign active   = enable && arm;
  assign mode1    = (rle_mode == RLE_LENGTH);
  assign fpos     = flag_pos(disabledGroups);
  assign fmask    = (DW'(1) << fpos) - DW'(1);
  assign flag_bit = DW'(1) << fpos;
  assign din_f    = sti_data & fmask;

  assign eq       = have_last_q && (din_f == last_q);
  assign cnt_inc  = cnt_q + DW'(1);
  assign cnt_emit = mode1 ? cnt_inc : cnt_q;
  // In length mode the emitted value is count+1, so saturate one repeat earlier.
  assign sat      = mode1 ? (cnt_inc + DW'(1) == fmask) : (cnt_inc == fmask);

  always_comb begin
    push_n      = 2'd0;
    push_w0     = '0;
    push_w1     = '0;
    cnt_d       = cnt_q;
    last_d      = last_q;
    have_last_d = have_last_q;
    if (!active) begin
      cnt_d       = '0;
      last_d      = '0;
      have_last_d = 1'b0;
    end else if (sti_valid) begin
      if (!have_last_q) begin
        push_n      = 2'd1;
        push_w0     = din_f;
        last_d      = din_f;
        have_last_d = 1'b1;
        cnt_d       = '0;
      end else if (eq) begin
        if (sat) begin
          push_n  = 2'd1;
          push_w0 = flag_bit | fmask;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        last_d = din_f;
        cnt_d  = '0;
        if (cnt_q != '0) begin
          push_n  = 2'd2;
          push_w0 = flag_bit | cnt_emit;
          push_w1 = din_f;
        end else begin
          push_n  = 2'd1;
          push_w0 = din_f;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      have_last_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      have_last_q <= have_last_d;
    end
  end

  always_ff @(posedge clk) begin
    last_q <= last_d;
  end

  rle_out_fifo #(.DW(DW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (!active),
    .push_n    (push_n),
    .push_w0   (push_w0),
    .push_w1   (push_w1),
    .pop       (1'b1),
    .head_vld  (head_vld),
    .head_data (head_data)
  );

  // Output stage: pass-through sample or queue head, registered once.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (!active) begin
      data_p1 <= sti_data;
      vld_p1  <= sti_valid;
    end else begin
      data_p1 <= head_data;
      vld_p1  <= head_vld;
    end
  end

  assign sto_data  = data_p1;
  assign sto_valid = vld_p1;

endmodule

// File: tb/tb_rle_encoder.sv
// Directed bench for rle_encoder: expected words with their arrival cycle are
// queued as stimulus is issued and checked by an independent output monitor.
module tb_rle_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        arm;
  logic [1:0]  rle_mode;
  logic [3:0]  disabledGroups;
  logic [31:0] sti_data;
  logic        sti_valid;
  logic [31:0] sto_data;
  logic        sto_valid;

  rle_encoder #(.DW(32), .KW(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .arm            (arm),
    .rle_mode       (rle_mode),
    .disabledGroups (disabledGroups),
    .sti_data       (sti_data),
    .sti_valid      (sti_valid),
    .sto_data       (sto_data),
    .sto_valid      (sto_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic        done = 1'b0;
  int          pr_id = 0;
  int          pr_seen = 0;
  string       pr_name;
  logic [31:0] pr_d;
  logic        pr_v;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input logic [31:0] d, input logic v);
    sti_data  = d;
    sti_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expw(input logic [31:0] d, input int lat);
    exp_t e;
    e.d = d;
    e.c = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic probe(input string name, input logic [31:0] d, input logic v);
    pr_name = name;
    pr_d    = d;
    pr_v    = v;
    pr_id   = pr_id + 1;
  endtask

  task automatic cfg(input logic [3:0] dg, input logic [1:0] md);
    enable = 1'b0;
    arm    = 1'b0;
    step(32'h0, 1'b0);
    disabledGroups = dg;
    rle_mode       = md;
    enable         = 1'b1;
    arm            = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0);
  endtask

  // Output monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pr_id != pr_seen) begin
        pr_seen = pr_id;
        total++;
        if (sto_data !== pr_d || sto_valid !== pr_v) begin
          bad++;
          $display("FAIL %s: got data=%h valid=%b, want data=%h valid=%b",
                   pr_name, sto_data, sto_valid, pr_d, pr_v);
        end
      end
      if (!rst && sto_valid === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_word: got %h at cycle %0d, want no word", sto_data, cyc);
        end else begin
          e = sb.pop_front();
          if (sto_data !== e.d || cyc != e.c) begin
            bad++;
            $display("FAIL out_word: got %h at cycle %0d, want %h at cycle %0d",
                     sto_data, cyc, e.d, e.c);
          end
        end
      end
      if (done) begin
        total++;
        if (sb.size() != 0) begin
          bad++;
          $display("FAIL missing_words: got %0d words still expected, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    enable         = 1'b0;
    arm            = 1'b0;
    rle_mode       = 2'd0;
    disabledGroups = 4'b0000;
    sti_data       = 32'h0;
    sti_valid      = 1'b0;
    idle(2);
    probe("reset_state", 32'h0, 1'b0);
    idle(1);
    rst = 1'b0;

    // pass-through
    expw(32'h41414141, 1);
    step(32'h41414141, 1'b1);
    step(32'h42424242, 1'b0);
    probe("pass_invalid", 32'h42424242, 1'b0);
    idle(1);

    // 8-bit, mode 0; upper junk on the first sample must be masked off
    cfg(4'b1110, 2'd0);
    expw(32'h41, 1);
    step(32'hA5A5A541, 1'b1);
    step(32'h42, 1'b0);
    expw(32'h43, 1);
    step(32'h43, 1'b1);
    step(32'h43, 1'b0);
    step(32'h43, 1'b0);
    step(32'h43, 1'b1);
    expw(32'h81, 1);
    expw(32'h44, 2);
    step(32'h44, 1'b1);
    step(32'h44, 1'b1);
    step(32'h44, 1'b1);
    expw(32'h82, 1);
    expw(32'h45, 2);
    step(32'h45, 1'b1);
    idle(3);

    // 8-bit saturation
    cfg(4'b1110, 2'd0);
    for (int i = 0; i < 129; i++) begin
      if (i == 0) expw(32'h4B, 1);
      if (i == 127) expw(32'hFF, 1);
      step(32'h4B, 1'b1);
    end
    expw(32'h81, 1);
    expw(32'h4C, 2);
    step(32'h4C, 1'b1);
    idle(3);

    // 16-bit
    cfg(4'b1100, 2'd0);
    for (int i = 0; i < 257; i++) begin
      if (i == 0) expw(32'h4F4F, 1);
      step(32'h12344F4F, 1'b1);
    end
    expw(32'h8100, 1);
    expw(32'h5050, 2);
    step(32'h5050, 1'b1);
    idle(3);

    // 32-bit
    cfg(4'b0000, 2'd0);
    for (int i = 0; i < 257; i++) begin
      if (i == 0) expw(32'h4F4F4F4F, 1);
      step(32'h4F4F4F4F, 1'b1);
    end
    expw(32'h80000100, 1);
    expw(32'h50505050, 2);
    step(32'h50505050, 1'b1);
    idle(3);

    // 24-bit
    cfg(4'b1000, 2'd0);
    expw(32'h123456, 1);
    step(32'hFF123456, 1'b1);
    step(32'hFF123456, 1'b1);
    expw(32'h800001, 1);
    expw(32'h000001, 2);
    step(32'h00000001, 1'b1);
    idle(3);

    // mode 1: full run length
    cfg(4'b1110, 2'd1);
    expw(32'h44, 1);
    step(32'h44, 1'b1);
    step(32'h44, 1'b1);
    step(32'h44, 1'b1);
    expw(32'h83, 1);
    expw(32'h45, 2);
    step(32'h45, 1'b1);
    idle(3);

    // mode 2 behaves as repeats
    cfg(4'b1110, 2'd2);
    expw(32'h10, 1);
    step(32'h10, 1'b1);
    step(32'h10, 1'b1);
    expw(32'h81, 1);
    expw(32'h11, 2);
    step(32'h11, 1'b1);
    idle(3);

    // enable dropped mid-run: count discarded, pass-through next cycle
    cfg(4'b1110, 2'd0);
    expw(32'h55, 1);
    for (int i = 0; i < 4; i++) step(32'h55, 1'b1);
    enable = 1'b0;
    expw(32'h55555555, 1);
    step(32'h55555555, 1'b1);
    expw(32'h66666666, 1);
    step(32'h66666666, 1'b1);
    idle(1);

    // enable dropped with a value word still queued: queue flushed
    cfg(4'b1110, 2'd0);
    expw(32'h55, 1);
    step(32'h55, 1'b1);
    step(32'h55, 1'b1);
    expw(32'h81, 1);
    step(32'h56, 1'b1);
    enable = 1'b0;
    expw(32'h77777777, 1);
    step(32'h77777777, 1'b1);
    idle(2);

    // reset mid-run: outputs cleared, first sample after release is a value
    cfg(4'b1110, 2'd0);
    expw(32'h5A, 1);
    for (int i = 0; i < 3; i++) step(32'h5A, 1'b1);
    rst = 1'b1;
    step(32'h5B, 1'b1);
    probe("reset_mid_run", 32'h0, 1'b0);
    rst = 1'b0;
    expw(32'h5B, 1);
    step(32'h5B, 1'b1);
    idle(3);

    done = 1'b1;
  end

endmodule
